// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multicycle ALU with start/busy/done handshake
//
// Single-cycle ops (add/sub/slt/or/and/sll/srl/beq) finish one cycle after
// acceptance. Unsigned mul (shift-add) and divu (restoring) take one bit per
// cycle and finish WIDTH+1 cycles after acceptance. Results are registered
// and held until the next completion.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                request, sampled while busy is low
//   opc, inpA, inpB      opcode and operands, captured at acceptance
//   res, res_hi          result low half / quotient, high half / remainder
//   zero, div_by_zero    flags registered with res
//   busy, done           iteration in progress, one-cycle completion pulse
module alu_seq #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opc,
  input  logic [WIDTH-1:0] inpA,
  input  logic [WIDTH-1:0] inpB,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             zero,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               is_div_q;
  logic [SHW-1:0]     cnt_q;
  logic [WIDTH-1:0]   res_q, res_hi_q;
  logic               zero_q, dbz_q;

  logic               accept, iter_op, last_iter;
  logic [WIDTH-1:0]   sc_res, sc_hi;
  logic               sc_dbz;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next, iter_next;

  // DONE does not count as busy, so back-to-back starts are taken there.
  assign accept    = start && (state_q != S_ITER);
  // Divide by zero skips iteration and is answered on the single-cycle path.
  assign iter_op   = (opc == 4'd6) || ((opc == 4'd7) && (inpB != '0));
  assign last_iter = (cnt_q == SHW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = iter_op ? S_ITER : S_DONE;
        else       state_d = S_IDLE;
      end
      S_ITER:  if (last_iter) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy        = (state_q == S_ITER);
    done        = (state_q == S_DONE);
    res         = res_q;
    res_hi      = res_hi_q;
    zero        = zero_q;
    div_by_zero = dbz_q;
  end

  // Single-cycle results
  always_comb begin
    sc_res = '0;
    sc_hi  = '0;
    sc_dbz = 1'b0;
    case (opc)
      4'd0: sc_res = inpA + inpB;
      4'd1: sc_res = inpA - inpB;
      4'd2: sc_res = {{(WIDTH-1){1'b0}}, ($signed(inpA) < $signed(inpB))};
      4'd3: sc_res = inpA | inpB;
      4'd4: sc_res = inpA & inpB;
      4'd5: sc_res = inpA << inpB[SHW-1:0];
      4'd7: begin
        // only reached with B==0
        sc_res = '1;
        sc_hi  = inpA;
        sc_dbz = 1'b1;
      end
      4'd8: sc_res = inpA >> inpB[SHW-1:0];
      4'd9: sc_res = inpA - inpB;
      default: sc_res = '0;
    endcase
  end

  // One iteration step. Mul: acc = {partial product, remaining multiplier},
  // add multiplicand into the top on a 1 bit, then shift right with carry.
  // Div: acc = {remainder, dividend/quotient}, shift left one bit, try to
  // subtract the divisor and shift the quotient bit in at the bottom.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    if (div_trial[WIDTH]) div_next = {acc_q[2*WIDTH-2:0], 1'b0};
    else                  div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    iter_next = is_div_q ? div_next : mul_next;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else if (accept) begin
      if (iter_op) begin
        acc_q    <= (opc == 4'd6) ? {{WIDTH{1'b0}}, inpB} : {{WIDTH{1'b0}}, inpA};
        opnd_q   <= (opc == 4'd6) ? inpA : inpB;
        is_div_q <= (opc == 4'd7);
        cnt_q    <= '0;
      end else begin
        res_q    <= sc_res;
        res_hi_q <= sc_hi;
        zero_q   <= (sc_res == '0);
        dbz_q    <= sc_dbz;
      end
    end else if (state_q == S_ITER) begin
      acc_q <= iter_next;
      cnt_q <= cnt_q + 1'b1;
      if (last_iter) begin
        res_q    <= iter_next[WIDTH-1:0];
        res_hi_q <= iter_next[2*WIDTH-1:WIDTH];
        zero_q   <= (iter_next[WIDTH-1:0] == '0);
        dbz_q    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        start16 = 1'b0;
  logic [3:0]  opc16 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [15:0] res16, hi16;
  logic        zero16, dbz16, busy16, done16;

  logic        start32 = 1'b0;
  logic [3:0]  opc32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [31:0] res32, hi32;
  logic        zero32, dbz32, busy32, done32;

  alu_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .opc(opc16), .inpA(a16), .inpB(b16),
    .res(res16), .res_hi(hi16), .zero(zero16), .div_by_zero(dbz16),
    .busy(busy16), .done(done16)
  );

  alu_seq #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .start(start32), .opc(opc32), .inpA(a32), .inpB(b32),
    .res(res32), .res_hi(hi32), .zero(zero32), .div_by_zero(dbz32),
    .busy(busy32), .done(done32)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  typedef struct {
    logic [3:0]  opc;
    logic [15:0] a, b;
    logic [15:0] res, hi;
    logic        zero;
  } vec_t;

  vec_t vecs[12];

  // Issues one iterative op on the 16-bit unit at a negedge and watches it
  // for WIDTH+6 cycles. With disturb set, operands change in cycle 3 and an
  // add request is pulsed in cycle 5 while busy.
  task automatic run_long(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                          input bit disturb, output int lat, output int busy_n, output int dones);
    start16 = 1'b1; opc16 = o; a16 = a; b16 = b;
    lat = 0; busy_n = 0; dones = 0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c == 1) start16 = 1'b0;
      if (disturb && c == 3) begin a16 = 16'h1234; b16 = 16'h5678; end
      if (disturb && c == 5) begin start16 = 1'b1; opc16 = 4'd0; end
      if (disturb && c == 6) start16 = 1'b0;
      if (busy16) busy_n++;
      if (done16) begin dones++; if (lat == 0) lat = c; end
    end
  endtask

  task automatic single(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    start16 = 1'b1; opc16 = o; a16 = a; b16 = b;
    @(negedge clk);
    start16 = 1'b0;
  endtask

  initial begin
    int lat, busy_n, dones;

    vecs[0]  = '{4'd0, 16'd8, 16'd2, 16'd10, 16'd0, 1'b0};
    vecs[1]  = '{4'd1, 16'd8, 16'd2, 16'd6,  16'd0, 1'b0};
    vecs[2]  = '{4'd3, 16'd8, 16'd2, 16'd10, 16'd0, 1'b0};
    vecs[3]  = '{4'd4, 16'd8, 16'd2, 16'd0,  16'd0, 1'b1};
    vecs[4]  = '{4'd5, 16'd8, 16'd2, 16'd32, 16'd0, 1'b0};
    vecs[5]  = '{4'd2, 16'd8, 16'd2, 16'd0,  16'd0, 1'b1};
    vecs[6]  = '{4'd8, 16'd8, 16'd2, 16'd2,  16'd0, 1'b0};
    vecs[7]  = '{4'd9, 16'd8, 16'd2, 16'd6,  16'd0, 1'b0};
    vecs[8]  = '{4'd9, 16'd5, 16'd5, 16'd0,  16'd0, 1'b1};
    vecs[9]  = '{4'd2, 16'hFFFF, 16'd1, 16'd1, 16'd0, 1'b0};
    vecs[10] = '{4'd5, 16'd1, 16'h0013, 16'd8, 16'd0, 1'b0};
    vecs[11] = '{4'd12, 16'd5, 16'd5, 16'd0, 16'd0, 1'b1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset res", res16, 0);
    check("reset res_hi", hi16, 0);
    check("reset zero", zero16, 0);
    check("reset dbz", dbz16, 0);
    check("reset busy", busy16, 0);
    check("reset done", done16, 0);
    check("reset res32", res32, 0);

    // Back-to-back: each op is requested in its predecessor's done cycle.
    @(negedge clk);
    start16 = 1'b1; opc16 = vecs[0].opc; a16 = vecs[0].a; b16 = vecs[0].b;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d done", i), done16, 1);
      check($sformatf("vec%0d res", i), res16, vecs[i].res);
      check($sformatf("vec%0d res_hi", i), hi16, vecs[i].hi);
      check($sformatf("vec%0d zero", i), zero16, vecs[i].zero);
      if (i < 11) begin
        opc16 = vecs[i+1].opc; a16 = vecs[i+1].a; b16 = vecs[i+1].b;
      end else start16 = 1'b0;
    end
    @(negedge clk);
    check("idle after ops done", done16, 0);

    run_long(4'd6, 16'd300, 16'd500, 1'b0, lat, busy_n, dones);
    check("mul latency", lat, 17);
    check("mul busy cycles", busy_n, 16);
    check("mul dones", dones, 1);
    check("mul res", res16, 16'h49F0);
    check("mul res_hi", hi16, 16'h0002);

    run_long(4'd7, 16'd100, 16'd7, 1'b0, lat, busy_n, dones);
    check("div latency", lat, 17);
    check("div res", res16, 14);
    check("div res_hi", hi16, 2);
    check("div dbz", dbz16, 0);

    single(4'd7, 16'd100, 16'd0);
    check("dbz done", done16, 1);
    check("dbz res", res16, 16'hFFFF);
    check("dbz res_hi", hi16, 16'd100);
    check("dbz flag", dbz16, 1);
    single(4'd0, 16'd8, 16'd2);
    check("dbz cleared res", res16, 10);
    check("dbz cleared flag", dbz16, 0);

    run_long(4'd6, 16'd300, 16'd500, 1'b1, lat, busy_n, dones);
    check("disturbed mul latency", lat, 17);
    check("disturbed mul dones", dones, 1);
    check("disturbed mul res", res16, 16'h49F0);
    check("disturbed mul res_hi", hi16, 16'h0002);

    // Abort a divide with reset in cycle 8; a simultaneous start must lose.
    start16 = 1'b1; opc16 = 4'd7; a16 = 16'd1000; b16 = 16'd3;
    dones = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) start16 = 1'b0;
      if (done16) dones++;
    end
    rst = 1'b1; start16 = 1'b1; opc16 = 4'd0; a16 = 16'd8; b16 = 16'd2;
    @(negedge clk);
    rst = 1'b0; start16 = 1'b0;
    check("abort res", res16, 0);
    check("abort res_hi", hi16, 0);
    check("abort zero", zero16, 0);
    check("abort busy", busy16, 0);
    check("abort done", done16, 0);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (done16) dones++;
    end
    check("abort no done", dones, 0);
    single(4'd0, 16'd8, 16'd2);
    check("post-abort add done", done16, 1);
    check("post-abort add res", res16, 10);

    // 32-bit build: 0xFFFFFFFF * 2
    start32 = 1'b1; opc32 = 4'd6; a32 = 32'hFFFFFFFF; b32 = 32'd2;
    lat = 0; busy_n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) start32 = 1'b0;
      if (busy32) busy_n++;
      if (done32 && lat == 0) lat = c;
    end
    check("mul32 latency", lat, 33);
    check("mul32 busy cycles", busy_n, 32);
    check("mul32 res", res32, 32'hFFFFFFFE);
    check("mul32 res_hi", hi32, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multicycle ALU for the CPU datapath, the next generation of the 16-bit combinational ALU. It keeps the existing opcode map for single-cycle operations, adds shift-right, unsigned multiply and unsigned divide, and registers all results behind a start/busy/done handshake. It sits in the execute stage; the control unit holds the pipeline while `busy` is high.

## Interface
- `WIDTH`, 16: operand/result width; must be ≥4 and a power of two.
- `SHW`, log2(WIDTH): shift-amount width, derived, not overridden.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only when `busy`=0.
- `opc` input 4: operation code, latched with `start`.
- `inpA` input WIDTH: operand A, latched with `start`.
- `inpB` input WIDTH: operand B, latched with `start`.
- `res` output WIDTH: result (low product / quotient for mul/div).
- `res_hi` output WIDTH: high product half (mul), remainder (div), 0 otherwise.
- `zero` output 1: 1 when `res` == 0; registered with `res`.
- `div_by_zero` output 1: 1 when the last completed op was div with B=0.
- `busy` output 1: operation in progress; new `start` ignored.
- `done` output 1: one-cycle pulse; `res`/`res_hi`/flags are valid from this cycle on.

## Operation
- Opcodes:
  - 0 add (A+B mod 2^WIDTH).
  - 1 sub (A−B).
  - 2 slt signed (res=1 if $signed(A)<$signed(B), else 0).
  - 3 or.
  - 4 and.
  - 5 sll (A << B[SHW-1:0]).
  - 6 mul unsigned.
  - 7 divu.
  - 8 srl (A >> B[SHW-1:0], zero fill).
  - 9 beq compare (res=A−B, so zero=1 iff A==B).
  - 10–15: res=0, res_hi=0, zero=1, single-cycle.
- FSM states:
  - IDLE → DONE on start with a single-cycle opcode, or with div and B=0.
  - IDLE → ITER on start with opc 6, or opc 7 with B≠0.
  - ITER → DONE after WIDTH iterations.
  - DONE → IDLE, or DONE → ITER/DONE if `start` is asserted in DONE (back-to-back is allowed because `busy`=0 in DONE).
- `busy` = (state==ITER). `done` = (state==DONE).
- Mul: shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator. `res` = low half, `res_hi` = high half.
- Div: restoring, one quotient bit per cycle. `res` = quotient, `res_hi` = remainder.
- Div by zero: `res` = all ones, `res_hi` = A, `div_by_zero` = 1; takes the single-cycle path.
- `div_by_zero` is cleared by the next completed op.
- Outputs hold their last completed values until the next DONE. Intermediate values never appear on `res`/`res_hi`.
- Operands and opcode are captured at acceptance; input changes afterwards have no effect.

## Timing
- Reset values: `res`=0, `res_hi`=0, `zero`=0, `div_by_zero`=0, `busy`=0, `done`=0, state IDLE, internal accumulators 0.
- Acceptance edge = rising edge with `start`=1 and `busy`=0 (cycle 0).
- Single-cycle ops and div-by-zero: `done`=1 in cycle 1 with results; latency 1.
- Mul/div: `busy`=1 in cycles 1..WIDTH, `done`=1 in cycle WIDTH+1, `busy`=0 in that cycle; latency WIDTH+1.
- `start` while `busy`=1 is dropped, not queued; no extra `done` results from it.
- `start` during the `done` cycle is accepted at the next edge. Throughput is one op per cycle for single-cycle ops.
- `rst` mid-operation:
  - Aborts at that edge and returns to IDLE with all outputs at reset values.
  - No `done` is produced for the aborted op.
  - `rst` has priority over a simultaneous `start`.

## Test plan
- Reset, then A=8, B=2 through opc 0,1,3,4,5,2,8,9:
  - `res` = 10, 6, 10, 0, 32, 0, 2, 6.
  - Each op has `done` 1 cycle after `start`.
  - opc 9 with A=B=5 gives `res`=0, `zero`=1.
- opc 6, A=300, B=500 (WIDTH=16):
  - `busy` for 16 cycles, `done` in cycle 17.
  - `res`=0x49F0, `res_hi`=0x0002.
- opc 7, A=100, B=7: `res`=14, `res_hi`=2 at cycle 17. Then A=100, B=0: `done` in cycle 1, `res`=0xFFFF, `res_hi`=100, `div_by_zero`=1.
- Start mul, pulse `start` with opc 0 at cycle 5:
  - The add is ignored.
  - Exactly one `done`, carrying the mul result.
  - Operand inputs changed at cycle 3 do not alter the result.
- Start div, assert `rst` at cycle 8:
  - All outputs 0 next cycle; no `done` ever appears.
  - A following add 8+2 gives `res`=10 with `done` at cycle 1.
- Back-to-back: add accepted in its predecessor's `done` cycle → consecutive `done` pulses. Then signed slt with A=0xFFFF, B=1 → `res`=1. Then WIDTH=32 build: mul 0xFFFFFFFF×2 → `res`=0xFFFFFFFE, `res_hi`=1, `done` at cycle 33.
